// File: rtl/ace_rle_encoder.sv
// Streams Jupiter Ace RAM out as a run-length encoded .ACE image (ED,count,byte records, ED,00 end).
// Optional trailing XOR checksum byte and csum port when ACE_SAVE_CSUM_EN is defined.
module ace_rle_encoder #(
  parameter logic [15:0] BASE_ADDR = 16'h2000,
  parameter logic [15:0] MEM_LEN   = 16'h6000,
  parameter int unsigned MIN_RUN   = 4,
  parameter int unsigned MAX_RUN   = 240
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_count
`ifdef ACE_SAVE_CSUM_EN
  ,
  output logic [7:0]  csum
`endif
);

  localparam logic [7:0] MIN_RUN_B = 8'(MIN_RUN);
  localparam logic [7:0] MAX_RUN_B = 8'(MAX_RUN);
  localparam logic [7:0] ESC_BYTE  = 8'hED;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SCAN,
    S_FLUSH,
    S_ESC,
    S_CNT,
    S_VAL,
    S_LIT,
    S_TERM_ED,
    S_TERM_00,
`ifdef ACE_SAVE_CSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] remaining_q, remaining_d;
  logic [7:0]  run_byte_q, run_byte_d;
  logic [7:0]  run_len_q, run_len_d;
  logic [7:0]  byte_q, byte_d;
  logic [23:0] count_q, count_d;
  logic [7:0]  csum_q, csum_d;
  logic        accept;
  state_t      flush_exit;

  // Output byte is a pure function of state, so it stays stable while stalled.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      S_ESC, S_TERM_ED: begin out_valid = 1'b1; out_data = ESC_BYTE;   end
      S_CNT:            begin out_valid = 1'b1; out_data = run_len_q;  end
      S_VAL, S_LIT:     begin out_valid = 1'b1; out_data = run_byte_q; end
      S_TERM_00:        begin out_valid = 1'b1; out_data = 8'h00;      end
`ifdef ACE_SAVE_CSUM_EN
      S_CSUM:           begin out_valid = 1'b1; out_data = csum_q;     end
`endif
      default: ;
    endcase
  end

  assign accept     = out_valid & out_ready;
  assign flush_exit = (remaining_q == 16'd0) ? S_TERM_ED : S_SCAN;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    run_byte_d  = run_byte_q;
    run_len_d   = run_len_q;
    byte_d      = byte_q;
    count_d     = count_q;
    csum_d      = csum_q;

    if (accept) begin
      if (count_q != 24'hFFFFFF) count_d = count_q + 24'd1;
`ifdef ACE_SAVE_CSUM_EN
      if (state_q != S_CSUM) csum_d = csum_q ^ out_data;
`endif
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          count_d     = 24'd0;
          csum_d      = 8'h00;
          rd_ptr_d    = BASE_ADDR;
          remaining_d = MEM_LEN;
          run_len_d   = 8'd0;
          state_d     = (MEM_LEN == 16'd0) ? S_TERM_ED : S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        byte_d  = mem_data;
        state_d = S_SCAN;
      end
      // A mismatching byte is not consumed here: the pending run is flushed
      // first and the byte is rescanned afterwards with run_len == 0.
      S_SCAN: begin
        if (run_len_q == 8'd0 || (byte_q == run_byte_q && run_len_q < MAX_RUN_B)) begin
          run_byte_d  = byte_q;
          run_len_d   = run_len_q + 8'd1;
          rd_ptr_d    = rd_ptr_q + 16'd1;
          remaining_d = remaining_q - 16'd1;
          state_d     = (remaining_q == 16'd1) ? S_FLUSH : S_FETCH;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = (run_byte_q == ESC_BYTE || run_len_q >= MIN_RUN_B) ? S_ESC : S_LIT;
      S_ESC:   if (accept) state_d = S_CNT;
      S_CNT:   if (accept) state_d = S_VAL;
      S_VAL: begin
        if (accept) begin
          run_len_d = 8'd0;
          state_d   = flush_exit;
        end
      end
      S_LIT: begin
        if (accept) begin
          run_len_d = run_len_q - 8'd1;
          if (run_len_q == 8'd1) state_d = flush_exit;
        end
      end
      S_TERM_ED: if (accept) state_d = S_TERM_00;
`ifdef ACE_SAVE_CSUM_EN
      S_TERM_00: if (accept) state_d = S_CSUM;
      S_CSUM:    if (accept) state_d = S_DONE;
`else
      S_TERM_00: if (accept) state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= BASE_ADDR;
      remaining_q <= 16'd0;
      run_byte_q  <= 8'h00;
      run_len_q   <= 8'd0;
      byte_q      <= 8'h00;
      count_q     <= 24'd0;
      csum_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      run_byte_q  <= run_byte_d;
      run_len_q   <= run_len_d;
      byte_q      <= byte_d;
      count_q     <= count_d;
      csum_q      <= csum_d;
    end
  end

  assign mem_addr  = rd_ptr_q;
  assign mem_rd    = (state_q == S_FETCH);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign out_count = count_q;
`ifdef ACE_SAVE_CSUM_EN
  assign csum      = csum_q;
`endif

endmodule

// File: tb/tb_ace_rle_encoder.sv
// Randomised scoreboard bench for ace_rle_encoder: a run-splitting reference model
// fills an expected-byte queue, a monitor pops and compares every accepted byte.
module tb_ace_rle_encoder;

  localparam logic [15:0] BASE = 16'hFF80;  // range wraps through 0xFFFF
  localparam int LEN  = 300;
  localparam int MINR = 4;
  localparam int MAXR = 240;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, done, mem_rd, out_valid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data, out_data;
  logic [23:0] out_count;
`ifdef ACE_SAVE_CSUM_EN
  logic [7:0]  csum;
`endif

  logic [7:0] ram [0:65535];
  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int stall_viol = 0;
  int rd_viol = 0;
  int ready_mode = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  ace_rle_encoder #(
    .BASE_ADDR(BASE), .MEM_LEN(16'(LEN)), .MIN_RUN(MINR), .MAX_RUN(MAXR)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count)
`ifdef ACE_SAVE_CSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) if (mem_rd) mem_data <= ram[mem_addr];

  always @(posedge clk_sys) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else out_ready = ($urandom_range(0, 99) >= 30);
  end

  // Monitor: pop and compare every accepted byte; track handshake rules.
  always @(negedge clk_sys) begin
    logic [7:0] e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (mem_rd && out_valid) rd_viol++;
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_byte: got %02h, required no byte (stream already complete)", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_byte: got %02h, required %02h (%0d left)", out_data, e, exp_q.size());
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fill(input int pat);
    int i;
    int n;
    logic [7:0] v;
    i = 0;
    while (i < LEN) begin
      case (pat)
        0: begin v = 8'h00; n = 1; end
        1: begin v = 8'($urandom); n = 1; end
        2: begin
          n = $urandom_range(1, 8);
          case ($urandom_range(0, 3))
            0: v = 8'h00;
            1: v = 8'hED;
            2: v = 8'h55;
            default: v = 8'($urandom);
          endcase
        end
        3: begin v = 8'hED; n = 1; end
        default: begin v = (i < 240) ? 8'hAA : 8'hBB; n = 1; end
      endcase
      for (int k = 0; k < n && i < LEN; k++) begin
        ram[16'(BASE + i)] = v;
        i++;
      end
    end
  endtask

  // Reference: cut the image into maximal equal-byte runs of at most MAXR bytes.
  task automatic model(output int n, output logic [7:0] x);
    logic [7:0] s[$];
    logic [7:0] b;
    int i;
    int j;
    i = 0;
    while (i < LEN) begin
      b = ram[16'(BASE + i)];
      j = i + 1;
      while (j < LEN && (j - i) < MAXR && ram[16'(BASE + j)] == b) j++;
      if (b == 8'hED || (j - i) >= MINR) begin
        s.push_back(8'hED);
        s.push_back(8'(j - i));
        s.push_back(b);
      end else begin
        for (int k = i; k < j; k++) s.push_back(b);
      end
      i = j;
    end
    s.push_back(8'hED);
    s.push_back(8'h00);
    x = 8'h00;
    foreach (s[k]) x ^= s[k];
`ifdef ACE_SAVE_CSUM_EN
    s.push_back(x);
`endif
    n = s.size();
    foreach (s[k]) exp_q.push_back(s[k]);
  endtask

  task automatic pulse_start();
    @(posedge clk_sys);
    #1 start = 1'b1;
    @(posedge clk_sys);
    #1 start = 1'b0;
  endtask

  task automatic recover();
    @(posedge clk_sys);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk_sys);
    #1 reset = 1'b0;
  endtask

  task automatic run_save(input int pat, input int stall, input int extra_start);
    int n;
    int cyc;
    logic [7:0] x;
    fill(pat);
    exp_q.delete();
    model(n, x);
    done_cnt = 0;
    stall_viol = 0;
    rd_viol = 0;
    ready_mode = stall;
    pulse_start();
    @(negedge clk_sys);
    check("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 20000) begin
      if (extra_start != 0 && cyc == 40) start = 1'b1;
      if (cyc == 41) start = 1'b0;
      @(negedge clk_sys);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", cyc);
      recover();
      return;
    end
    repeat (3) @(negedge clk_sys);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("bytes_left", 32'(exp_q.size()), 32'd0);
    check("out_count", 32'(out_count), 32'(n));
    check("stall_stable", 32'(stall_viol), 32'd0);
    check("rd_while_pending", 32'(rd_viol), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
`ifdef ACE_SAVE_CSUM_EN
    check("csum", 32'(csum), 32'(x));
`endif
    $display("save pattern=%0d stall=%0d restart=%0d bytes=%0d out_count=%0d cycles=%0d",
             pat, stall, extra_start, n, out_count, cyc);
  endtask

  initial begin
    int cyc;
    int n;
    logic [7:0] x;
    // Reset state, with start held during reset (reset must win).
    start = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'(BASE));
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    @(posedge clk_sys);
    #1 reset = 1'b0;
    start = 1'b0;
    @(negedge clk_sys);
    check("start_during_reset", 32'(busy), 32'd0);

    for (int it = 0; it < 10; it++) run_save(it % 5, it / 5, (it == 7) ? 1 : 0);

    // Abort mid-output with reset, then a fresh save must reproduce the full stream.
    fill(0);
    exp_q.delete();
    model(n, x);
    ready_mode = 0;
    pulse_start();
    cyc = 0;
    while (!out_valid && cyc < 3000) begin
      @(negedge clk_sys);
      cyc++;
    end
    check("abort_reached_output", 32'(out_valid), 32'd1);
    @(negedge clk_sys);
    @(posedge clk_sys);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_count", 32'(out_count), 32'd0);
    $display("abort after %0d cycles of scanning", cyc);
    run_save(0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
